arm_decode: RTL and testbench

- Instruction decoder for the single-cycle ARM datapath. Sits between instruction fetch/condition check and the register_file, shiftee_mux, shifter_mux, barrel_shifter and arm_alu.
- Decodes a 32-bit ARM instruction (data processing, single load/store, branch) into register indices, write enables and mux/operation selects.
- All outputs are registered, one cycle after the inputs.

---
 rtl/arm_decode_pkg.sv | 40 ++++
 rtl/arm_operand_decode.sv | 59 +++++
 rtl/arm_decode.sv | 133 +++++++++++++
 tb/tb_arm_decode.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/arm_decode_pkg.sv
// Shared encodings for the ARM instruction decoder: DP opcodes, shifter
// select codes, barrel shift types and the instruction-class enum.
package arm_decode_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMN = 4'b1011;

    localparam logic [3:0] BARREL_LSL = 4'b0000;
    localparam logic [3:0] BARREL_LSR = 4'b0001;
    localparam logic [3:0] BARREL_ASR = 4'b0010;
    localparam logic [3:0] BARREL_ROR = 4'b0011;
    localparam logic [3:0] BARREL_RRX = 4'b0100;

    localparam logic [1:0] SHIFTER_ROT_IMM   = 2'b00;
    localparam logic [1:0] SHIFTER_SHIFT_IMM = 2'b01;
    localparam logic [1:0] SHIFTER_RS        = 2'b10;

    localparam logic [3:0] LINK_REG = 4'hE;

    typedef enum logic [1:0] {
        CLASS_DP,
        CLASS_LS,
        CLASS_BR,
        CLASS_UNDEF
    } inst_class_t;

    // op is inst[27:25]
    function automatic inst_class_t decode_class(input logic [2:0] op);
        casez (op)
            3'b00?:  return CLASS_DP;
            3'b01?:  return CLASS_LS;
            3'b101:  return CLASS_BR;
            default: return CLASS_UNDEF;
        endcase
    endfunction

endpackage

// File: rtl/arm_operand_decode.sv
// Combinational shifter-operand decode: picks shiftee source, shift-amount
// source and barrel shift type from the instruction class and operand bits.
module arm_operand_decode
    import arm_decode_pkg::*;
(
    input  inst_class_t iclass,
    input  logic        imm_bit,
    input  logic [7:0]  shift_ctl,
    output logic        shiftee_sel,
    output logic [1:0]  shifter_sel,
    output logic [3:0]  barrel_sel
);

    logic [4:0] shift_imm;
    logic [1:0] shift_type;
    logic       reg_shift;
    logic [1:0] reg_form_shifter;
    logic [3:0] reg_form_barrel;

    assign shift_imm  = shift_ctl[7:3];
    assign shift_type = shift_ctl[2:1];
    assign reg_shift  = shift_ctl[0];

    // Register-form operand shared by DP (I=0) and LS register offsets.
    always_comb begin
        reg_form_shifter = reg_shift ? SHIFTER_RS : SHIFTER_SHIFT_IMM;
        reg_form_barrel  = {2'b00, shift_type};
        if (!reg_shift && shift_type == 2'b11 && shift_imm == 5'd0) begin
            reg_form_barrel = BARREL_RRX;
        end
    end

    always_comb begin
        shiftee_sel = 1'b0;
        shifter_sel = SHIFTER_ROT_IMM;
        barrel_sel  = BARREL_LSL;
        case (iclass)
            CLASS_DP: begin
                if (imm_bit) begin
                    shiftee_sel = 1'b1;
                    barrel_sel  = BARREL_ROR;
                end else begin
                    shifter_sel = reg_form_shifter;
                    barrel_sel  = reg_form_barrel;
                end
            end
            CLASS_LS: begin
                if (!imm_bit) begin
                    shiftee_sel = 1'b1;
                end else begin
                    shifter_sel = reg_form_shifter;
                    barrel_sel  = reg_form_barrel;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/arm_decode.sv
// Registered ARM instruction decoder for the single-cycle datapath: turns
// DP, load/store and branch words into register indices, enables and selects.
module arm_decode
    import arm_decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cond_pass,
    input  logic [31:0] inst,
    output logic [3:0]  write_rd,
    output logic [3:0]  read_rn,
    output logic [3:0]  read_rm,
    output logic [3:0]  read_rs,
    output logic        rd_we,
    output logic        pc_we,
    output logic        cpsr_we,
    output logic [31:0] rd_in,
    output logic [31:0] pc_in,
    output logic [31:0] cpsr_in,
    output logic        shiftee_sel,
    output logic [7:0]  immed_8_shiftee_in,
    output logic [1:0]  shifter_sel,
    output logic [3:0]  rotate_imm_shifter_in,
    output logic [4:0]  shift_imm_shifter_in,
    output logic [3:0]  alu_sel,
    output logic [3:0]  barrel_sel
);

    inst_class_t iclass;
    logic [3:0]  opcode;
    logic [3:0]  next_write_rd;
    logic        next_rd_we;
    logic        next_pc_we;
    logic        next_cpsr_we;
    logic [31:0] next_rd_in;
    logic [31:0] next_pc_in;
    logic [3:0]  next_alu_sel;
    logic        next_shiftee_sel;
    logic [1:0]  next_shifter_sel;
    logic [3:0]  next_barrel_sel;
    logic        unused_cond;

    // Condition field is evaluated upstream and arrives as cond_pass.
    assign unused_cond = ^inst[31:28];

    assign iclass = decode_class(inst[27:25]);
    assign opcode = inst[24:21];

    arm_operand_decode u_operand_decode (
        .iclass      (iclass),
        .imm_bit     (inst[25]),
        .shift_ctl   (inst[11:4]),
        .shiftee_sel (next_shiftee_sel),
        .shifter_sel (next_shifter_sel),
        .barrel_sel  (next_barrel_sel)
    );

    always_comb begin
        next_write_rd = 4'd0;
        next_rd_we    = 1'b0;
        next_pc_we    = 1'b0;
        next_cpsr_we  = 1'b0;
        next_rd_in    = 32'd0;
        next_pc_in    = 32'd0;
        next_alu_sel  = 4'd0;
        case (iclass)
            CLASS_DP: begin
                next_write_rd = inst[15:12];
                next_alu_sel  = opcode;
                // TST/TEQ/CMP/CMN only set flags.
                next_rd_we    = cond_pass && !(opcode >= OP_TST && opcode <= OP_CMN);
                next_cpsr_we  = cond_pass & inst[20];
            end
            CLASS_LS: begin
                next_write_rd = inst[15:12];
                next_rd_we    = cond_pass & inst[20];
                next_alu_sel  = inst[23] ? OP_ADD : OP_SUB;
                next_rd_in    = {20'd0, inst[11:0]};
            end
            CLASS_BR: begin
                next_pc_we    = cond_pass;
                next_pc_in    = {{6{inst[23]}}, inst[23:0], 2'b00};
                next_alu_sel  = OP_ADD;
                if (inst[24]) begin
                    next_write_rd = LINK_REG;
                    next_rd_we    = cond_pass;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_rd              <= 4'd0;
            read_rn               <= 4'd0;
            read_rm               <= 4'd0;
            read_rs               <= 4'd0;
            rd_we                 <= 1'b0;
            pc_we                 <= 1'b0;
            cpsr_we               <= 1'b0;
            rd_in                 <= 32'd0;
            pc_in                 <= 32'd0;
            cpsr_in               <= 32'd0;
            shiftee_sel           <= 1'b0;
            immed_8_shiftee_in    <= 8'd0;
            shifter_sel           <= 2'd0;
            rotate_imm_shifter_in <= 4'd0;
            shift_imm_shifter_in  <= 5'd0;
            alu_sel               <= 4'd0;
            barrel_sel            <= 4'd0;
        end else begin
            write_rd              <= next_write_rd;
            read_rn               <= inst[19:16];
            read_rm               <= inst[3:0];
            read_rs               <= inst[11:8];
            rd_we                 <= next_rd_we;
            pc_we                 <= next_pc_we;
            cpsr_we               <= next_cpsr_we;
            rd_in                 <= next_rd_in;
            pc_in                 <= next_pc_in;
            cpsr_in               <= 32'd0;
            shiftee_sel           <= next_shiftee_sel;
            immed_8_shiftee_in    <= inst[7:0];
            shifter_sel           <= next_shifter_sel;
            rotate_imm_shifter_in <= inst[11:8];
            shift_imm_shifter_in  <= inst[11:7];
            alu_sel               <= next_alu_sel;
            barrel_sel            <= next_barrel_sel;
        end
    end

endmodule

// File: tb/tb_arm_decode.sv
// Directed testbench for arm_decode: hand-decoded ARM words checked one
// cycle after they are applied, plus reset and cond_pass behaviour.
module tb_arm_decode;

    logic        clk;
    logic        rst_n;
    logic        cond_pass;
    logic [31:0] inst;
    logic [3:0]  write_rd;
    logic [3:0]  read_rn;
    logic [3:0]  read_rm;
    logic [3:0]  read_rs;
    logic        rd_we;
    logic        pc_we;
    logic        cpsr_we;
    logic [31:0] rd_in;
    logic [31:0] pc_in;
    logic [31:0] cpsr_in;
    logic        shiftee_sel;
    logic [7:0]  immed_8_shiftee_in;
    logic [1:0]  shifter_sel;
    logic [3:0]  rotate_imm_shifter_in;
    logic [4:0]  shift_imm_shifter_in;
    logic [3:0]  alu_sel;
    logic [3:0]  barrel_sel;

    int testsRun;
    int testsFailed;

    arm_decode dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .cond_pass             (cond_pass),
        .inst                  (inst),
        .write_rd              (write_rd),
        .read_rn               (read_rn),
        .read_rm               (read_rm),
        .read_rs               (read_rs),
        .rd_we                 (rd_we),
        .pc_we                 (pc_we),
        .cpsr_we               (cpsr_we),
        .rd_in                 (rd_in),
        .pc_in                 (pc_in),
        .cpsr_in               (cpsr_in),
        .shiftee_sel           (shiftee_sel),
        .immed_8_shiftee_in    (immed_8_shiftee_in),
        .shifter_sel           (shifter_sel),
        .rotate_imm_shifter_in (rotate_imm_shifter_in),
        .shift_imm_shifter_in  (shift_imm_shifter_in),
        .alu_sel               (alu_sel),
        .barrel_sel            (barrel_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one word, let it be registered, sample 1 time unit after the edge.
    task automatic applyStimulus(input logic [31:0] word, input logic cond);
        inst      = word;
        cond_pass = cond;
        @(posedge clk);
        #1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        cond_pass   = 1'b1;
        inst        = 32'hE2011002;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset write_rd", 32'(write_rd), 32'd0);
        checkOutput("reset alu_sel", 32'(alu_sel), 32'd0);
        checkOutput("reset rd_we", 32'(rd_we), 32'd0);
        checkOutput("reset barrel_sel", 32'(barrel_sel), 32'd0);
        checkOutput("reset immed_8", 32'(immed_8_shiftee_in), 32'd0);
        rst_n = 1'b1;

        // AND R1,R1,#2
        applyStimulus(32'hE2011002, 1'b1);
        checkOutput("and write_rd", 32'(write_rd), 32'd1);
        checkOutput("and read_rn", 32'(read_rn), 32'd1);
        checkOutput("and rd_we", 32'(rd_we), 32'd1);
        checkOutput("and cpsr_we", 32'(cpsr_we), 32'd0);
        checkOutput("and alu_sel", 32'(alu_sel), 32'h0);
        checkOutput("and shiftee_sel", 32'(shiftee_sel), 32'd1);
        checkOutput("and shifter_sel", 32'(shifter_sel), 32'b00);
        checkOutput("and immed_8", 32'(immed_8_shiftee_in), 32'h02);
        checkOutput("and rotate_imm", 32'(rotate_imm_shifter_in), 32'h0);
        checkOutput("and barrel_sel", 32'(barrel_sel), 32'b0011);
        checkOutput("and pc_we", 32'(pc_we), 32'd0);

        // BIC R9,R8,#0xFF00
        applyStimulus(32'hE3C89CFF, 1'b1);
        checkOutput("bic write_rd", 32'(write_rd), 32'd9);
        checkOutput("bic read_rn", 32'(read_rn), 32'd8);
        checkOutput("bic alu_sel", 32'(alu_sel), 32'b1110);
        checkOutput("bic immed_8", 32'(immed_8_shiftee_in), 32'hFF);
        checkOutput("bic rotate_imm", 32'(rotate_imm_shifter_in), 32'hC);
        checkOutput("bic rd_we", 32'(rd_we), 32'd1);

        // ADD R4,R3,R2
        applyStimulus(32'hE0834002, 1'b1);
        checkOutput("add write_rd", 32'(write_rd), 32'd4);
        checkOutput("add read_rn", 32'(read_rn), 32'd3);
        checkOutput("add read_rm", 32'(read_rm), 32'd2);
        checkOutput("add alu_sel", 32'(alu_sel), 32'b0100);
        checkOutput("add shiftee_sel", 32'(shiftee_sel), 32'd0);
        checkOutput("add shifter_sel", 32'(shifter_sel), 32'b01);
        checkOutput("add shift_imm", 32'(shift_imm_shifter_in), 32'd0);
        checkOutput("add barrel_sel", 32'(barrel_sel), 32'b0000);

        // CMP R7,R8
        applyStimulus(32'hE1570008, 1'b1);
        checkOutput("cmp alu_sel", 32'(alu_sel), 32'b1010);
        checkOutput("cmp rd_we", 32'(rd_we), 32'd0);
        checkOutput("cmp cpsr_we", 32'(cpsr_we), 32'd1);
        checkOutput("cmp read_rn", 32'(read_rn), 32'd7);
        checkOutput("cmp read_rm", 32'(read_rm), 32'd8);

        // SUB R10,R9,R8,LSR #4
        applyStimulus(32'hE049A228, 1'b1);
        checkOutput("sub write_rd", 32'(write_rd), 32'd10);
        checkOutput("sub read_rn", 32'(read_rn), 32'd9);
        checkOutput("sub read_rm", 32'(read_rm), 32'd8);
        checkOutput("sub alu_sel", 32'(alu_sel), 32'b0010);
        checkOutput("sub shift_imm", 32'(shift_imm_shifter_in), 32'd4);
        checkOutput("sub barrel_sel", 32'(barrel_sel), 32'b0001);

        // MOV R2,R0,LSL #2
        applyStimulus(32'hE1A02100, 1'b1);
        checkOutput("mov write_rd", 32'(write_rd), 32'd2);
        checkOutput("mov shift_imm", 32'(shift_imm_shifter_in), 32'd2);
        checkOutput("mov alu_sel", 32'(alu_sel), 32'b1101);

        // MOV R0,R0,RRX (ROR #0)
        applyStimulus(32'hE1A00060, 1'b1);
        checkOutput("rrx barrel_sel", 32'(barrel_sel), 32'b0100);
        checkOutput("rrx shifter_sel", 32'(shifter_sel), 32'b01);

        // MOV R1,R2,LSL R3
        applyStimulus(32'hE1A01312, 1'b1);
        checkOutput("regshift shifter_sel", 32'(shifter_sel), 32'b10);
        checkOutput("regshift read_rs", 32'(read_rs), 32'd3);
        checkOutput("regshift barrel_sel", 32'(barrel_sel), 32'b0000);

        // LDR R2,[R1,#4]
        applyStimulus(32'hE5912004, 1'b1);
        checkOutput("ldr write_rd", 32'(write_rd), 32'd2);
        checkOutput("ldr rd_we", 32'(rd_we), 32'd1);
        checkOutput("ldr alu_sel", 32'(alu_sel), 32'b0100);
        checkOutput("ldr rd_in", rd_in, 32'h4);
        checkOutput("ldr shiftee_sel", 32'(shiftee_sel), 32'd1);
        checkOutput("ldr cpsr_we", 32'(cpsr_we), 32'd0);

        // STR R2,[R1,#-4]
        applyStimulus(32'hE5012004, 1'b1);
        checkOutput("str rd_we", 32'(rd_we), 32'd0);
        checkOutput("str alu_sel", 32'(alu_sel), 32'b0010);

        // BL with offset -2 words
        applyStimulus(32'hEBFFFFFE, 1'b1);
        checkOutput("bl pc_we", 32'(pc_we), 32'd1);
        checkOutput("bl pc_in", pc_in, 32'hFFFFFFF8);
        checkOutput("bl write_rd", 32'(write_rd), 32'hE);
        checkOutput("bl rd_we", 32'(rd_we), 32'd1);
        checkOutput("bl alu_sel", 32'(alu_sel), 32'b0100);

        // Undefined class
        applyStimulus(32'hEE000000, 1'b1);
        checkOutput("undef rd_we", 32'(rd_we), 32'd0);
        checkOutput("undef pc_we", 32'(pc_we), 32'd0);
        checkOutput("undef alu_sel", 32'(alu_sel), 32'd0);

        // ADD R4,R3,R2 with condition failing
        applyStimulus(32'hE0834002, 1'b0);
        checkOutput("nocond rd_we", 32'(rd_we), 32'd0);
        checkOutput("nocond cpsr_we", 32'(cpsr_we), 32'd0);
        checkOutput("nocond pc_we", 32'(pc_we), 32'd0);
        checkOutput("nocond alu_sel", 32'(alu_sel), 32'b0100);

        // Asynchronous reset mid-stream, sampled before the next edge
        applyStimulus(32'hE3C89CFF, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async write_rd", 32'(write_rd), 32'd0);
        checkOutput("async rd_we", 32'(rd_we), 32'd0);
        checkOutput("async alu_sel", 32'(alu_sel), 32'd0);
        checkOutput("async immed_8", 32'(immed_8_shiftee_in), 32'd0);
        checkOutput("async read_rn", 32'(read_rn), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
